// File: rtl/spart_driver_if.sv
// Control half of the spart processor bus: chip select, direction, address and the two status wires.
// The shared 8-bit data bus stays a plain tri-state port on the driver.
interface spart_bus_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
   modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// spart_driver: bus master that programs the spart baud divisor from br_cfg, then echoes received bytes.
// Optional build macro SPART_DRV_UPCASE_EN: echo lower-case ASCII (8'h61..8'h7A) as upper case.
module spart_driver #(
   parameter logic [15:0] DIV_4800  = 16'h0515,
   parameter logic [15:0] DIV_9600  = 16'h028A,
   parameter logic [15:0] DIV_19200 = 16'h0145,
   parameter logic [15:0] DIV_38400 = 16'h00A2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         br_cfg,
   spart_bus_if.master        bus,
   inout  wire  [7:0]         databus,
   output logic [7:0]         rx_byte,
   output logic [15:0]        echo_cnt
);

   typedef enum logic [2:0] {
      LOAD_LO, LOAD_HI, IDLE, READ, WAIT_TX, WRITE, GAP
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  br_meta_q, br_s_q;
   logic [1:0]  br_q, br_d;
   logic        iocs_q, iocs_d;
   logic        iorw_q, iorw_d;
   logic [1:0]  addr_q, addr_d;
   logic [7:0]  dout_q, dout_d;
   logic [7:0]  rx_byte_q;
   logic [15:0] echo_cnt_q, echo_cnt_d;
   logic [15:0] div_sel;
   logic [7:0]  echo_byte;

   function automatic logic [15:0] divisor(input logic [1:0] sel);
      case (sel)
         2'b00:   return DIV_4800;
         2'b01:   return DIV_9600;
         2'b10:   return DIV_19200;
         default: return DIV_38400;
      endcase
   endfunction

   // LOAD_LO programs the freshly synchronised setting; LOAD_HI reuses the value latched with it.
   assign div_sel = divisor((state_q == LOAD_LO) ? br_s_q : br_q);

`ifdef SPART_DRV_UPCASE_EN
   assign echo_byte = (rx_byte_q >= 8'h61 && rx_byte_q <= 8'h7A) ? rx_byte_q - 8'h20 : rx_byte_q;
`else
   assign echo_byte = rx_byte_q;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d    = state_q;
      br_d       = br_q;
      iocs_d     = 1'b0;
      iorw_d     = 1'b1;
      addr_d     = 2'b00;
      dout_d     = 8'h00;
      echo_cnt_d = echo_cnt_q;

      case (state_q)
         LOAD_LO: begin
            iocs_d  = 1'b1;
            iorw_d  = 1'b0;
            addr_d  = 2'b10;
            dout_d  = div_sel[7:0];
            br_d    = br_s_q;
            state_d = LOAD_HI;
         end
         LOAD_HI: begin
            iocs_d  = 1'b1;
            iorw_d  = 1'b0;
            addr_d  = 2'b11;
            dout_d  = div_sel[15:8];
            state_d = IDLE;
         end
         IDLE: begin
            if (br_s_q != br_q) state_d = LOAD_LO;
            else if (bus.rda)   state_d = READ;
         end
         READ: begin
            iocs_d  = 1'b1;
            state_d = WAIT_TX;
         end
         WAIT_TX: begin
            if (bus.tbr) state_d = WRITE;
         end
         WRITE: begin
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            dout_d     = echo_byte;
            echo_cnt_d = echo_cnt_q + 16'd1;
            state_d    = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = LOAD_LO;
      endcase
   end

   // Bus outputs are registered from the current state, so each access is visible one cycle later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= LOAD_LO;
         br_meta_q  <= 2'b00;
         br_s_q     <= 2'b00;
         br_q       <= 2'b00;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         addr_q     <= 2'b00;
         dout_q     <= 8'h00;
         rx_byte_q  <= 8'h00;
         echo_cnt_q <= 16'h0000;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         br_meta_q  <= br_cfg;
         br_s_q     <= br_meta_q;
         br_q       <= br_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         echo_cnt_q <= echo_cnt_d;
         if (iocs_q && iorw_q) rx_byte_q <= databus;
      end
   end

   assign bus.iocs   = iocs_q;
   assign bus.iorw   = iorw_q;
   assign bus.ioaddr = addr_q;
   assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
   assign rx_byte    = rx_byte_q;
   assign echo_cnt   = echo_cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a spart stand-in answers reads, a scoreboard queue holds the expected
// bus accesses and a negedge monitor compares every access the driver makes.
module tb_spart_driver;

   localparam logic [7:0] KEEP = 8'hC3;

   typedef struct packed {
      logic       rw;
      logic [1:0] addr;
      logic [7:0] data;
   } xact_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  br_cfg = 2'b01;
   logic [7:0]  rx_data = 8'h00;
   wire  [7:0]  databus;
   logic [7:0]  rx_byte;
   logic [15:0] echo_cnt;

   xact_t       exp_q[$];
   int          checks  = 0;
   int          errors  = 0;
   int          cyc     = 0;
   int          rd_cyc  = -1;
   int          wr_cyc  = -1;
   int          exp_cnt = 0;

   spart_bus_if bus();

   spart_driver dut (
      .clk      (clk),
      .rst      (rst),
      .br_cfg   (br_cfg),
      .bus      (bus),
      .databus  (databus),
      .rx_byte  (rx_byte),
      .echo_cnt (echo_cnt)
   );

   // spart stand-in: returns rx_data on reads; otherwise drives a marker so a driver that fails to release shows up.
   assign databus = (bus.iocs && !bus.iorw) ? 8'hzz : (bus.iocs ? rx_data : KEEP);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic rw, input logic [1:0] addr, input logic [7:0] data);
      xact_t x;
      x.rw = rw; x.addr = addr; x.data = data;
      exp_q.push_back(x);
   endtask

   // Monitor: each chip-select cycle must match the head of the queue; idle cycles must release the bus.
   always @(negedge clk) begin
      xact_t e;
      if (rst) begin
         if (bus.iocs) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access: iorw=%0b addr=%0h data=%0h at cycle %0d",
                        bus.iorw, bus.ioaddr, databus, cyc);
            end else begin
               e = exp_q.pop_front();
               check("bus_iorw", 32'(bus.iorw), 32'(e.rw));
               check("bus_ioaddr", 32'(bus.ioaddr), 32'(e.addr));
               if (!e.rw) check("bus_wdata", 32'(databus), 32'(e.data));
            end
            if (bus.iorw) rd_cyc = cyc;
            else          wr_cyc = cyc;
         end else begin
            check("idle_iorw", 32'(bus.iorw), 32'd1);
            check("idle_databus_released", 32'(databus), 32'(KEEP));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait until at most `level` expected accesses remain; a timeout is a failed check.
   task automatic wait_q(input int level, input string name, output bit ok);
      int n = 0;
      while (exp_q.size() > level && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      ok = (exp_q.size() <= level);
      if (!ok) begin
         errors++;
         $display("FAIL %s: %0d accesses still pending, expected %0d", name, exp_q.size(), level);
         exp_q.delete();
      end
   endtask

   task automatic echo(input logic [7:0] b, input logic [7:0] w, input int tbr_delay);
      bit ok;
      int tbr_cyc;
      rx_data = b;
      bus.tbr = (tbr_delay == 0);
      push(1'b1, 2'b00, 8'h00);
      push(1'b0, 2'b00, w);
      bus.rda = 1'b1;
      wait_q(1, "read_seen", ok);
      bus.rda = 1'b0;
      if (!ok) return;
      tbr_cyc = -1;
      if (tbr_delay > 0) begin
         tick(tbr_delay);
         check("no_write_before_tbr", 32'(exp_q.size()), 32'd1);
         bus.tbr = 1'b1;
         tbr_cyc = cyc;
      end
      wait_q(0, "write_seen", ok);
      if (!ok) return;
      exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      check("rx_byte", 32'(rx_byte), 32'(b));
      check("echo_cnt", 32'(echo_cnt), 32'(exp_cnt));
      if (tbr_delay == 0) check("read_to_write_latency", 32'(wr_cyc - rd_cyc), 32'd2);
      else                check("tbr_to_write_latency", 32'(wr_cyc - tbr_cyc), 32'd2);
      tick(3);
   endtask

   initial begin
      bit ok;
      bus.rda = 1'b0;
      bus.tbr = 1'b0;

      // Reset state.
      tick(3);
      check("rst_iocs", 32'(bus.iocs), 32'd0);
      check("rst_iorw", 32'(bus.iorw), 32'd1);
      check("rst_ioaddr", 32'(bus.ioaddr), 32'd0);
      check("rst_databus", 32'(databus), 32'(KEEP));
      check("rst_rx_byte", 32'(rx_byte), 32'd0);
      check("rst_echo_cnt", 32'(echo_cnt), 32'd0);

      // Reset release with br_cfg=01. The synchroniser still reads 00 in the first LOAD_LO,
      // so 4800 baud is written first and the 9600 divisor follows once br_s settles.
      push(1'b0, 2'b10, 8'h15);
      push(1'b0, 2'b11, 8'h05);
      push(1'b0, 2'b10, 8'h8A);
      push(1'b0, 2'b11, 8'h02);
      @(negedge clk);
      #2 rst = 1'b1;
      wait_q(0, "initial_divisor_load", ok);
      tick(20);
      check("quiet_while_no_rda", 32'(bus.iocs), 32'd0);

      // Plain echo, then an echo held off by tbr for 10 cycles.
      echo(8'h41, 8'h41, 0);
      echo(8'h35, 8'h35, 10);

      // br_cfg 01 -> 11; rda rises as br_s changes, and the reload must come first.
      br_cfg = 2'b11;
      tick(2);
      push(1'b0, 2'b10, 8'hA2);
      push(1'b0, 2'b11, 8'h00);
      echo(8'h5A, 8'h5A, 0);

      // Reset asserted in the middle of the write cycle.
      rx_data = 8'h22;
      bus.tbr = 1'b1;
      push(1'b1, 2'b00, 8'h00);
      push(1'b0, 2'b00, 8'h22);
      bus.rda = 1'b1;
      wait_q(0, "write_before_reset", ok);
      bus.rda = 1'b0;
      check("cnt_before_reset", 32'(echo_cnt), 32'(exp_cnt + 1));
      rst = 1'b0;
      #1;
      check("rst_mid_write_iocs", 32'(bus.iocs), 32'd0);
      check("rst_mid_write_databus", 32'(databus), 32'(KEEP));
      check("rst_mid_write_cnt", 32'(echo_cnt), 32'd0);
      exp_cnt = 0;
      push(1'b0, 2'b10, 8'h15);
      push(1'b0, 2'b11, 8'h05);
      push(1'b0, 2'b10, 8'hA2);
      push(1'b0, 2'b11, 8'h00);
      tick(2);
      @(negedge clk);
      #2 rst = 1'b1;
      wait_q(0, "reload_after_reset", ok);
      tick(3);

      // Counter wrap from 16'hFFFF, combined with the case-folding boundaries.
      force dut.echo_cnt_q = 16'hFFFF;
      tick(1);
      release dut.echo_cnt_q;
      tick(1);
      check("cnt_preload", 32'(echo_cnt), 32'hFFFF);
      exp_cnt = 16'hFFFF;
`ifdef SPART_DRV_UPCASE_EN
      echo(8'h61, 8'h41, 0);
      check("cnt_wrapped", 32'(echo_cnt), 32'd0);
      echo(8'h7A, 8'h5A, 0);
      echo(8'h7B, 8'h7B, 0);
      echo(8'h60, 8'h60, 0);
`else
      echo(8'h61, 8'h61, 0);
      check("cnt_wrapped", 32'(echo_cnt), 32'd0);
      echo(8'h7A, 8'h7A, 0);
      echo(8'h7B, 8'h7B, 0);
`endif

      tick(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
